// File: rtl/corr_window_acc.sv
// Purpose: sliding-window complex correlator gamma[k] = sum over last WIN_LEN samples of r[k]*conj(r[k-N]).
// Latency: 3 cycles from an accepted in_valid to out_valid plus the matching gamma; one sample per cycle.
// Backpressure: none; a valid bit travels with the data and idle cycles simply hold the window state.
//
// Ports: clk, rst_n (async active-low), clear (sync flush), in_valid, rk_re/rk_im = r[k],
//        rkn_re/rkn_im = r[k-N], out_valid, win_full, gamma_re/gamma_im.
// Build option: define CORR_SAT_EN to saturate both OUT_W reductions; otherwise they wrap.
module corr_window_acc #(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 6,
    parameter int OUT_W    = 14,
    parameter int OUT_FRAC = 8,
    parameter int WIN_LEN  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  rk_re,
    input  logic signed [IN_W-1:0]  rk_im,
    input  logic signed [IN_W-1:0]  rkn_re,
    input  logic signed [IN_W-1:0]  rkn_im,
    output logic                    out_valid,
    output logic                    win_full,
    output logic signed [OUT_W-1:0] gamma_re,
    output logic signed [OUT_W-1:0] gamma_im
);
    localparam int PROD_W = 2 * IN_W;
    localparam int SUM_W  = 2 * IN_W + 1;
    localparam int SH     = 2 * IN_FRAC - OUT_FRAC;
    localparam int ACC_W  = OUT_W + $clog2(WIN_LEN);
    localparam int RED_W  = (SUM_W > ACC_W) ? SUM_W : ACC_W;
    localparam int PTR_W  = $clog2(WIN_LEN);
    localparam int CNT_W  = $clog2(WIN_LEN + 1);

    // Shared OUT_W reduction for the S2 product and the accumulator output.
    function automatic logic signed [OUT_W-1:0] reduce(input logic signed [RED_W-1:0] v);
`ifdef CORR_SAT_EN
        logic signed [RED_W-1:0] hi;
        logic signed [RED_W-1:0] lo;
        hi = {{(RED_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo = ~hi;
        if (v > hi)
            reduce = hi[OUT_W-1:0];
        else if (v < lo)
            reduce = lo[OUT_W-1:0];
        else
            reduce = v[OUT_W-1:0];
`else
        reduce = v[OUT_W-1:0];
`endif
    endfunction

    // ---------------- S1: full-precision partial products ----------------
    logic signed [PROD_W-1:0] a_x, b_x, c_x, d_x;
    logic signed [PROD_W-1:0] p_ac, p_bd, p_bc, p_ad;
    logic                     v1;

    assign a_x = PROD_W'(rk_re);
    assign b_x = PROD_W'(rk_im);
    assign c_x = PROD_W'(rkn_re);
    assign d_x = PROD_W'(rkn_im);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; p_ac <= '0; p_bd <= '0; p_bc <= '0; p_ad <= '0;
        end else if (clear) begin
            v1 <= 1'b0; p_ac <= '0; p_bd <= '0; p_bc <= '0; p_ad <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                p_ac <= a_x * c_x;
                p_bd <= b_x * d_x;
                p_bc <= b_x * c_x;
                p_ad <= a_x * d_x;
            end
        end
    end

    // ---------------- S2: conj multiply sum, floor shift, reduce ----------------
    logic signed [SUM_W-1:0] re_sh, im_sh;
    logic signed [OUT_W-1:0] s2_re, s2_im;
    logic                    v2;

    assign re_sh = (SUM_W'(p_ac) + SUM_W'(p_bd)) >>> SH;
    assign im_sh = (SUM_W'(p_bc) - SUM_W'(p_ad)) >>> SH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0; s2_re <= '0; s2_im <= '0;
        end else if (clear) begin
            v2 <= 1'b0; s2_re <= '0; s2_im <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                s2_re <= reduce(RED_W'(re_sh));
                s2_im <= reduce(RED_W'(im_sh));
            end
        end
    end

    // ---------------- S3: circular window and running sum ----------------
    // Slots start at zero, so the running sum during fill is the partial sum.
    logic signed [OUT_W-1:0] slot_re [WIN_LEN];
    logic signed [OUT_W-1:0] slot_im [WIN_LEN];
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        cnt;
    logic                    v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                slot_re[i] <= '0;
                slot_im[i] <= '0;
            end
            acc_re <= '0; acc_im <= '0; wr_ptr <= '0; cnt <= '0; v3 <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                slot_re[i] <= '0;
                slot_im[i] <= '0;
            end
            acc_re <= '0; acc_im <= '0; wr_ptr <= '0; cnt <= '0; v3 <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                // The slot being overwritten holds the sample leaving the window.
                acc_re          <= acc_re + ACC_W'(s2_re) - ACC_W'(slot_re[wr_ptr]);
                acc_im          <= acc_im + ACC_W'(s2_im) - ACC_W'(slot_im[wr_ptr]);
                slot_re[wr_ptr] <= s2_re;
                slot_im[wr_ptr] <= s2_im;
                wr_ptr          <= (wr_ptr == PTR_W'(WIN_LEN - 1)) ? '0 : wr_ptr + 1'b1;
                if (cnt != CNT_W'(WIN_LEN))
                    cnt <= cnt + 1'b1;
            end
        end
    end

    // ---------------- Output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0; win_full <= 1'b0; gamma_re <= '0; gamma_im <= '0;
        end else if (clear) begin
            out_valid <= 1'b0; win_full <= 1'b0; gamma_re <= '0; gamma_im <= '0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                gamma_re <= reduce(RED_W'(acc_re));
                gamma_im <= reduce(RED_W'(acc_im));
                win_full <= (cnt == CNT_W'(WIN_LEN));
            end
        end
    end
endmodule

// File: tb/tb_corr_window_acc.sv
// Purpose: randomized + directed scoreboard bench for corr_window_acc with a queue-based window model.
// Latency: expects each accepted sample's gamma 3 edges after acceptance.
// Backpressure: none; a monitor checks every cycle independently of the stimulus process.
module tb_corr_window_acc;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 14;
    localparam int WIN_LEN = 16;
    localparam int SH      = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic signed [IN_W-1:0] rk_re = '0, rk_im = '0, rkn_re = '0, rkn_im = '0;
    logic out_valid, win_full;
    logic signed [OUT_W-1:0] gamma_re, gamma_im;

    corr_window_acc dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .rk_re(rk_re), .rk_im(rk_im), .rkn_re(rkn_re), .rkn_im(rkn_im),
        .out_valid(out_valid), .win_full(win_full),
        .gamma_re(gamma_re), .gamma_im(gamma_im)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int re;
        int im;
        bit full;
        bit is_clr;
    } exp_t;

    exp_t exp_q[$];
    int   mdl_re[$];
    int   mdl_im[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int to_out(input int v);
        int t;
`ifdef CORR_SAT_EN
        if (v > (1 << (OUT_W - 1)) - 1) t = (1 << (OUT_W - 1)) - 1;
        else if (v < -(1 << (OUT_W - 1))) t = -(1 << (OUT_W - 1));
        else t = v;
`else
        t = v & ((1 << OUT_W) - 1);
        if (t >= (1 << (OUT_W - 1))) t = t - (1 << OUT_W);
`endif
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mdl_re.delete();
        mdl_im.delete();
    endtask

    // One cycle of stimulus; the values are sampled on the next rising edge.
    task automatic drive(input bit v, input bit clr, input int a, input int b, input int c, input int d);
        int   edge_n, sr, si;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        clear    = clr;
        rk_re    = a[IN_W-1:0];
        rk_im    = b[IN_W-1:0];
        rkn_re   = c[IN_W-1:0];
        rkn_im   = d[IN_W-1:0];
        edge_n   = cyc + 1;
        if (clr) begin
            // Anything not yet presented at the clearing edge never appears.
            while (exp_q.size() > 0 && exp_q[$].due >= edge_n) void'(exp_q.pop_back());
            model_reset();
            e.due = edge_n; e.re = 0; e.im = 0; e.full = 1'b0; e.is_clr = 1'b1;
            exp_q.push_back(e);
        end else if (v) begin
            // r[k]*conj(r[k-N]) = (ac+bd) + j(bc-ad), floored to OUT_FRAC then reduced.
            mdl_re.push_back(to_out((a * c + b * d) >>> SH));
            mdl_im.push_back(to_out((b * c - a * d) >>> SH));
            if (mdl_re.size() > WIN_LEN) begin
                void'(mdl_re.pop_front());
                void'(mdl_im.pop_front());
            end
            sr = 0;
            si = 0;
            foreach (mdl_re[i]) begin
                sr += mdl_re[i];
                si += mdl_im[i];
            end
            e.due = edge_n + 3; e.re = to_out(sr); e.im = to_out(si);
            e.full = (mdl_re.size() == WIN_LEN); e.is_clr = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_win_full", int'(win_full), 0);
        chk("async_rst_gamma_re", int'(gamma_re), 0);
        chk("async_rst_gamma_im", int'(gamma_im), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int pick();
        case ($urandom_range(0, 4))
            0: return -128;
            1: return 127;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    // Monitor: compares every cycle against the scoreboard head or the held value.
    int hold_re = 0, hold_im = 0, hold_full = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_gamma_re", int'(gamma_re), 0);
                chk("rst_gamma_im", int'(gamma_im), 0);
                chk("rst_win_full", int'(win_full), 0);
                hold_re = 0; hold_im = 0; hold_full = 0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_output: due edge %0d not seen, now edge %0d", exp_q[0].due, cyc);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    if (exp_q[0].is_clr) begin
                        chk("clr_out_valid", int'(out_valid), 0);
                        hold_re = 0; hold_im = 0; hold_full = 0;
                    end else begin
                        chk("out_valid", int'(out_valid), 1);
                        hold_re   = exp_q[0].re;
                        hold_im   = exp_q[0].im;
                        hold_full = int'(exp_q[0].full);
                    end
                    void'(exp_q.pop_front());
                end else begin
                    chk("idle_out_valid", int'(out_valid), 0);
                end
                chk("gamma_re", int'(gamma_re), hold_re);
                chk("gamma_im", int'(gamma_im), hold_im);
                chk("win_full", int'(win_full), hold_full);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Impulse, idle hold, then eviction by 16 zero samples.
        drive(1'b1, 1'b0, 64, 0, 64, 0);
        idle(6);
        for (int i = 0; i < WIN_LEN; i++) drive(1'b1, 1'b0, 0, 0, 0, 0);
        idle(4);

        // Constant fill.
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 64, 0, 0, 64);
        idle(4);

        // Same samples with gaps.
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < WIN_LEN; i++) begin
            drive(1'b1, 1'b0, 64, 0, 0, 64);
            drive(1'b0, 1'b0, 0, 0, 0, 0);
        end
        idle(4);

        // Saturation / wrap boundary.
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, -128, 0, -128, 0);
        idle(4);

        // Clear mid-window with in_valid held high.
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 64, 0, 64, 0);
        drive(1'b1, 1'b1, 64, 0, 64, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 64, 0, 64, 0);
        idle(4);

        // Async reset mid-stream, then constant fill again.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 64, 0, 0, 64);
        async_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 64, 0, 0, 64);
        idle(4);

        // Randomized traffic with sporadic clears.
        for (int i = 0; i < 500; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, pick(), pick(), pick(), pick());
        idle(6);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
